pipe_regfile: RTL and testbench

Parametrised register file with write-through bypass and a pending-write scoreboard, replacing the fixed 8×16 latch-based register bank in the pipelined CPU. It sits between the IF/RD station and the RD/EX station. It serves two operand reads per cycle and accepts one write-back per cycle. It tracks registers with in-flight writes so that decode can stall on RAW and WAW hazards instead of reading stale data.

---
 rtl/pipe_regfile.sv | 109 ++++++++++
 tb/tb_pipe_regfile.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_regfile.sv
// Parametrised register file with write-through bypass and a pending-write
// scoreboard that lets decode stall on RAW/WAW hazards.
module pipe_regfile #(
    parameter int WIDTH    = 16,
    parameter int NREGS    = 8,
    parameter bit ZERO_REG = 1'b0,
    parameter int CNT_W    = 16,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_dst,
    input  logic             use_a,
    input  logic             use_b,
    output logic             stall,
    output logic             busy_a,
    output logic             busy_b,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    // Issue handshake: issue_en is the request and stall the back-pressure.
    // The instruction is accepted on the edge where issue_en=1 and stall=0;
    // while stall=1 decode holds issue_dst/use_x/rd_addr_x unchanged.

    logic [WIDTH-1:0] r_mem [NREGS];
    logic [NREGS-1:0] r_pending;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_zero_a;
    logic             w_zero_b;
    logic             w_zero_dst;
    logic             w_hit_a;
    logic             w_hit_b;
    logic             w_hit_dst;
    logic             w_waw;
    logic             w_wr_ok;
    logic             w_accept;
    logic [NREGS-1:0] w_pend_nxt;

    always_comb begin
        w_zero_a   = ZERO_REG && (rd_addr_a == '0);
        w_zero_b   = ZERO_REG && (rd_addr_b == '0);
        w_zero_dst = ZERO_REG && (issue_dst == '0);
        w_hit_a    = wr_en && (wr_addr == rd_addr_a);
        w_hit_b    = wr_en && (wr_addr == rd_addr_b);
        w_hit_dst  = wr_en && (wr_addr == issue_dst);
        w_wr_ok    = wr_en && !(ZERO_REG && (wr_addr == '0));

        rd_data_a = w_zero_a ? '0 : (w_hit_a ? wr_data : r_mem[rd_addr_a]);
        rd_data_b = w_zero_b ? '0 : (w_hit_b ? wr_data : r_mem[rd_addr_b]);

        // A same-cycle write-back resolves the hazard through the bypass.
        busy_a = !w_zero_a && r_pending[rd_addr_a] && !w_hit_a;
        busy_b = !w_zero_b && r_pending[rd_addr_b] && !w_hit_b;
        w_waw  = !w_zero_dst && r_pending[issue_dst] && !w_hit_dst;

        stall    = issue_en && ((use_a && busy_a) || (use_b && busy_b) || w_waw);
        w_accept = issue_en && !stall && !w_zero_dst;
    end

    // Flush beats everything; otherwise write-back clears, then issue sets.
    always_comb begin
        w_pend_nxt = r_pending;
        if (flush) begin
            w_pend_nxt = '0;
        end else begin
            if (wr_en) begin
                w_pend_nxt[wr_addr] = 1'b0;
            end
            if (w_accept) begin
                w_pend_nxt[issue_dst] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending   <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_pending <= w_pend_nxt;
            if (stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_regfile.sv
// Directed bench for pipe_regfile: three builds (default, ZERO_REG=1, wide 32x16
// with a 4-bit stall counter) checked through an expected-value scoreboard.
module tb_pipe_regfile;

    logic clk;
    logic rst_n;

    // default build
    logic [2:0]  rd_addr_a, rd_addr_b, wr_addr, issue_dst;
    logic [15:0] rd_data_a, rd_data_b, wr_data, stall_cnt;
    logic        wr_en, issue_en, use_a, use_b, stall, busy_a, busy_b, flush;

    // ZERO_REG=1 build
    logic [2:0]  z_rd_addr_a, z_rd_addr_b, z_wr_addr, z_issue_dst;
    logic [15:0] z_rd_data_a, z_rd_data_b, z_wr_data, z_stall_cnt;
    logic        z_wr_en, z_issue_en, z_use_a, z_use_b, z_stall, z_busy_a, z_busy_b, z_flush;

    // WIDTH=32, NREGS=16, CNT_W=4 build
    logic [3:0]  w_rd_addr_a, w_rd_addr_b, w_wr_addr, w_issue_dst;
    logic [31:0] w_rd_data_a, w_rd_data_b, w_wr_data;
    logic [3:0]  w_stall_cnt;
    logic        w_wr_en, w_issue_en, w_use_a, w_use_b, w_stall, w_busy_a, w_busy_b, w_flush;

    pipe_regfile dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_dst(issue_dst), .use_a(use_a), .use_b(use_b),
        .stall(stall), .busy_a(busy_a), .busy_b(busy_b),
        .flush(flush), .stall_cnt(stall_cnt)
    );

    pipe_regfile #(.ZERO_REG(1'b1)) dut_z (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_a(z_rd_addr_a), .rd_addr_b(z_rd_addr_b),
        .rd_data_a(z_rd_data_a), .rd_data_b(z_rd_data_b),
        .wr_en(z_wr_en), .wr_addr(z_wr_addr), .wr_data(z_wr_data),
        .issue_en(z_issue_en), .issue_dst(z_issue_dst), .use_a(z_use_a), .use_b(z_use_b),
        .stall(z_stall), .busy_a(z_busy_a), .busy_b(z_busy_b),
        .flush(z_flush), .stall_cnt(z_stall_cnt)
    );

    pipe_regfile #(.WIDTH(32), .NREGS(16), .CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_a(w_rd_addr_a), .rd_addr_b(w_rd_addr_b),
        .rd_data_a(w_rd_data_a), .rd_data_b(w_rd_data_b),
        .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
        .issue_en(w_issue_en), .issue_dst(w_issue_dst), .use_a(w_use_a), .use_b(w_use_b),
        .stall(w_stall), .busy_a(w_busy_a), .busy_b(w_busy_b),
        .flush(w_flush), .stall_cnt(w_stall_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    localparam int S_RDA = 0, S_RDB = 1, S_BSA = 2, S_BSB = 3, S_STL = 4, S_CNT = 5;
    localparam int S_ZRDA = 10, S_ZSTL = 11, S_ZBSA = 12;
    localparam int S_WRDA = 20, S_WCNT = 21, S_WSTL = 22;

    logic [31:0] exp_q[$];
    int          sel_q[$];
    int          n_vec = 0;
    int          n_bad = 0;

    function automatic string sel_name(int sel);
        case (sel)
            S_RDA:   return "rd_data_a";
            S_RDB:   return "rd_data_b";
            S_BSA:   return "busy_a";
            S_BSB:   return "busy_b";
            S_STL:   return "stall";
            S_CNT:   return "stall_cnt";
            S_ZRDA:  return "z_rd_data_a";
            S_ZSTL:  return "z_stall";
            S_ZBSA:  return "z_busy_a";
            S_WRDA:  return "w_rd_data_a";
            S_WCNT:  return "w_stall_cnt";
            S_WSTL:  return "w_stall";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic [31:0] actual(int sel);
        case (sel)
            S_RDA:   return {16'h0, rd_data_a};
            S_RDB:   return {16'h0, rd_data_b};
            S_BSA:   return {31'h0, busy_a};
            S_BSB:   return {31'h0, busy_b};
            S_STL:   return {31'h0, stall};
            S_CNT:   return {16'h0, stall_cnt};
            S_ZRDA:  return {16'h0, z_rd_data_a};
            S_ZSTL:  return {31'h0, z_stall};
            S_ZBSA:  return {31'h0, z_busy_a};
            S_WRDA:  return w_rd_data_a;
            S_WCNT:  return {28'h0, w_stall_cnt};
            S_WSTL:  return {31'h0, w_stall};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic expect_val(input int sel, input logic [31:0] val);
        sel_q.push_back(sel);
        exp_q.push_back(val);
    endtask

    // Monitor: outputs are combinational or settled registers, so everything
    // queued during a cycle is compared on the falling edge of that cycle.
    always @(negedge clk) begin
        while (sel_q.size() > 0) begin
            int          s;
            logic [31:0] e;
            logic [31:0] a;
            s = sel_q.pop_front();
            e = exp_q.pop_front();
            a = actual(s);
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", sel_name(s), a, e, $time);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        rd_addr_a = '0; rd_addr_b = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_dst = '0; use_a = 1'b0; use_b = 1'b0; flush = 1'b0;
        z_rd_addr_a = '0; z_rd_addr_b = '0; z_wr_en = 1'b0; z_wr_addr = '0; z_wr_data = '0;
        z_issue_en = 1'b0; z_issue_dst = '0; z_use_a = 1'b0; z_use_b = 1'b0; z_flush = 1'b0;
        w_rd_addr_a = '0; w_rd_addr_b = '0; w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0;
        w_issue_en = 1'b0; w_issue_dst = '0; w_use_a = 1'b0; w_use_b = 1'b0; w_flush = 1'b0;
    endtask

    task automatic do_issue(input logic [2:0] dst);
        issue_en = 1'b1; issue_dst = dst; use_a = 1'b0; use_b = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] addr, input logic [15:0] data);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_all();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // reset state
        expect_val(S_RDA, 32'h0); expect_val(S_RDB, 32'h0);
        expect_val(S_BSA, 32'h0); expect_val(S_STL, 32'h0); expect_val(S_CNT, 32'h0);
        expect_val(S_WRDA, 32'h0); expect_val(S_WCNT, 32'h0);
        step();

        // write r3 with bypass, then from storage
        do_write(3'd3, 16'h1234); rd_addr_a = 3'd3;
        expect_val(S_RDA, 32'h1234);
        step();
        wr_en = 1'b0;
        expect_val(S_RDA, 32'h1234); expect_val(S_BSA, 32'h0);
        step();

        // asynchronous reset mid-cycle clears storage immediately
        rst_n = 1'b0;
        expect_val(S_RDA, 32'h0);
        step();
        rst_n = 1'b1;
        idle_all();
        step();

        // RAW stall on r5, held three cycles, then resolved by bypass
        do_issue(3'd5);
        expect_val(S_STL, 32'h0);
        step();
        do_issue(3'd1); use_a = 1'b1; rd_addr_a = 3'd5;
        expect_val(S_STL, 32'h1); expect_val(S_BSA, 32'h1);
        step();
        step();
        step();
        do_write(3'd5, 16'h00AA);
        expect_val(S_CNT, 32'd3); expect_val(S_STL, 32'h0);
        expect_val(S_RDA, 32'h00AA); expect_val(S_BSA, 32'h0);
        step();
        idle_all(); rd_addr_a = 3'd5; rd_addr_b = 3'd1;
        expect_val(S_RDA, 32'h00AA); expect_val(S_BSA, 32'h0);
        expect_val(S_BSB, 32'h1); expect_val(S_CNT, 32'd3);
        step();

        // WAW on r2, then write-back and re-issue on the same edge
        idle_all();
        do_issue(3'd2);
        expect_val(S_STL, 32'h0);
        step();
        expect_val(S_STL, 32'h1);
        step();
        do_write(3'd2, 16'h0202);
        expect_val(S_STL, 32'h0);
        step();
        idle_all(); rd_addr_a = 3'd2;
        expect_val(S_BSA, 32'h1); expect_val(S_RDA, 32'h0202); expect_val(S_CNT, 32'd4);
        step();

        // flush with concurrent issue and write-back
        idle_all();
        do_issue(3'd4);
        step();
        do_issue(3'd6);
        step();
        idle_all();
        rd_addr_a = 3'd6; rd_addr_b = 3'd1;
        flush = 1'b1; do_issue(3'd7); do_write(3'd4, 16'd9);
        expect_val(S_BSA, 32'h1); expect_val(S_BSB, 32'h1); expect_val(S_STL, 32'h0);
        step();
        idle_all(); rd_addr_a = 3'd4; rd_addr_b = 3'd7;
        expect_val(S_RDA, 32'd9); expect_val(S_BSA, 32'h0);
        expect_val(S_BSB, 32'h0); expect_val(S_RDB, 32'h0);
        step();
        rd_addr_a = 3'd6; rd_addr_b = 3'd2;
        expect_val(S_BSA, 32'h0); expect_val(S_BSB, 32'h0); expect_val(S_CNT, 32'd4);
        do_issue(3'd7);
        expect_val(S_STL, 32'h0);
        step();
        idle_all();

        // ZERO_REG build: r0 hardwired, dst 0 never stalls
        z_wr_en = 1'b1; z_wr_addr = 3'd0; z_wr_data = 16'hFFFF; z_rd_addr_a = 3'd0;
        expect_val(S_ZRDA, 32'h0);
        step();
        z_wr_en = 1'b0; z_issue_en = 1'b1; z_issue_dst = 3'd0;
        expect_val(S_ZRDA, 32'h0); expect_val(S_ZSTL, 32'h0);
        step();
        z_use_a = 1'b1;
        expect_val(S_ZSTL, 32'h0); expect_val(S_ZBSA, 32'h0);
        step();
        z_issue_en = 1'b0; z_use_a = 1'b0;
        z_wr_en = 1'b1; z_wr_addr = 3'd1; z_wr_data = 16'h0055; z_rd_addr_a = 3'd1;
        expect_val(S_ZRDA, 32'h0055);
        step();
        idle_all();

        // wide build: 32-bit data in r15, 4-bit stall counter saturates
        w_wr_en = 1'b1; w_wr_addr = 4'd15; w_wr_data = 32'hDEADBEEF; w_rd_addr_a = 4'd15;
        expect_val(S_WRDA, 32'hDEADBEEF);
        step();
        w_wr_en = 1'b0; w_issue_en = 1'b1; w_issue_dst = 4'd3;
        expect_val(S_WRDA, 32'hDEADBEEF); expect_val(S_WSTL, 32'h0);
        step();
        expect_val(S_WSTL, 32'h1);
        for (int i = 0; i < 20; i++) begin
            step();
        end
        expect_val(S_WCNT, 32'd15); expect_val(S_WSTL, 32'h1);
        step();
        expect_val(S_WCNT, 32'd15);
        step();
        idle_all();
        step();
        step();

        if (sel_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d unchecked entries expected 0", sel_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
